// File: rtl/dfi_data_sched_pkg.sv
// Shared sizing constants and types for the DFI data-timing stage.
package dfi_data_sched_pkg;

  localparam int DATA_WIDTH    = 128;
  localparam int MASK_WIDTH    = 16;
  localparam int ID_WIDTH      = 4;
  localparam int BURST_CYCLES  = 4;
  localparam int MAX_LAT       = 16;
  localparam int RD_FIFO_DEPTH = 8;

  localparam int LAT_W   = $clog2(MAX_LAT) + 1;
  localparam int BEAT_W  = $clog2(BURST_CYCLES);
  localparam int FIFO_AW = $clog2(RD_FIFO_DEPTH);

  typedef logic [ID_WIDTH-1:0] id_t;
  typedef logic [BEAT_W-1:0]   beat_t;

  typedef struct packed {
    logic valid;
    id_t  id;
  } lat_entry_t;

  typedef enum logic {IDLE, BURST} eng_state_e;

  localparam beat_t LAST_BEAT = beat_t'(BURST_CYCLES - 1);

endpackage

// File: rtl/dfi_data_sched_if.sv
// Command, write-buffer, DFI data and read-response signals of the data-timing stage.
interface dfi_data_sched_if;
  import dfi_data_sched_pkg::*;

  logic [LAT_W-1:0]      cfg_wr_lat;
  logic [LAT_W-1:0]      cfg_rd_lat;
  logic                  wr_cmd_valid;
  id_t                   wr_cmd_id;
  logic                  rd_cmd_valid;
  id_t                   rd_cmd_id;
  logic                  wbuf_req;
  id_t                   wbuf_id;
  beat_t                 wbuf_beat;
  logic [DATA_WIDTH-1:0] wbuf_data;
  logic [MASK_WIDTH-1:0] wbuf_mask;
  logic                  dfi_wrdata_en;
  logic [DATA_WIDTH-1:0] dfi_wrdata;
  logic [MASK_WIDTH-1:0] dfi_wrdata_mask;
  logic                  dfi_rddata_en;
  logic                  dfi_rddata_valid;
  logic [DATA_WIDTH-1:0] dfi_rddata;
  logic                  rd_rsp_valid;
  id_t                   rd_rsp_id;
  logic                  rd_rsp_last;
  logic [DATA_WIDTH-1:0] rd_rsp_data;
  logic                  err_wr_overlap;
  logic                  err_rd_overlap;
  logic                  err_rd_overflow;
  logic                  err_rd_unexpected;

  modport slave (
    input  cfg_wr_lat, cfg_rd_lat, wr_cmd_valid, wr_cmd_id, rd_cmd_valid, rd_cmd_id,
           wbuf_data, wbuf_mask, dfi_rddata_valid, dfi_rddata,
    output wbuf_req, wbuf_id, wbuf_beat, dfi_wrdata_en, dfi_wrdata, dfi_wrdata_mask,
           dfi_rddata_en, rd_rsp_valid, rd_rsp_id, rd_rsp_last, rd_rsp_data,
           err_wr_overlap, err_rd_overlap, err_rd_overflow, err_rd_unexpected
  );

  modport master (
    output cfg_wr_lat, cfg_rd_lat, wr_cmd_valid, wr_cmd_id, rd_cmd_valid, rd_cmd_id,
           wbuf_data, wbuf_mask, dfi_rddata_valid, dfi_rddata,
    input  wbuf_req, wbuf_id, wbuf_beat, dfi_wrdata_en, dfi_wrdata, dfi_wrdata_mask,
           dfi_rddata_en, rd_rsp_valid, rd_rsp_id, rd_rsp_last, rd_rsp_data,
           err_wr_overlap, err_rd_overlap, err_rd_overflow, err_rd_unexpected
  );

endinterface

// File: rtl/dfi_data_sched_lat_delay_line.sv
// Command shift line with a programmable tap: tap shows din delayed by lat-1 cycles,
// so an engine registering the tap raises its enable exactly lat cycles after the command.
module dfi_lat_delay_line
  import dfi_data_sched_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  lat_entry_t       din,
  input  logic [LAT_W-1:0] lat,
  output lat_entry_t       tap
);

  // line_q[k] holds din delayed by k+1 cycles
  lat_entry_t line_q [MAX_LAT-1];
  lat_entry_t line_d [MAX_LAT-1];

  always_comb begin
    line_d[0] = din;
    for (int k = 1; k < MAX_LAT - 1; k++) line_d[k] = line_q[k-1];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < MAX_LAT - 1; k++) line_q[k] <= '0;
    end else begin
      for (int k = 0; k < MAX_LAT - 1; k++) line_q[k] <= line_d[k];
    end
  end

  always_comb begin
    tap = din;
    for (int k = 0; k < MAX_LAT - 1; k++) begin
      if (lat == LAT_W'(k + 2)) tap = line_q[k];
    end
  end

endmodule

// File: rtl/dfi_data_sched.sv
// DFI data-timing stage: times wrdata_en/rddata_en bursts from command issue,
// fetches write beats from the write buffer and tags returned read beats.
//   state | meaning
//   IDLE  | no burst on this data enable
//   BURST | enable high, beat counter walking 0..BURST_CYCLES-1
module dfi_data_sched
  import dfi_data_sched_pkg::*;
(
  input logic             clk,
  input logic             rst_n,
  dfi_data_sched_if.slave bus
);

  localparam logic [FIFO_AW:0] CNT_ONE  = (FIFO_AW + 1)'(1);
  localparam logic [FIFO_AW:0] CNT_FULL = (FIFO_AW + 1)'(RD_FIFO_DEPTH);

  lat_entry_t wr_in, rd_in, wr_tap, rd_tap;

  assign wr_in = {bus.wr_cmd_valid, bus.wr_cmd_id};
  assign rd_in = {bus.rd_cmd_valid, bus.rd_cmd_id};

  dfi_lat_delay_line u_wr_line (.clk(clk), .rst_n(rst_n), .din(wr_in), .lat(bus.cfg_wr_lat), .tap(wr_tap));
  dfi_lat_delay_line u_rd_line (.clk(clk), .rst_n(rst_n), .din(rd_in), .lat(bus.cfg_rd_lat), .tap(rd_tap));

  // Read bursts are untagged on the DFI side; the tag travels through the ID FIFO.
  logic unused_rd_tap_id;
  assign unused_rd_tap_id = ^rd_tap.id;

  eng_state_e wr_state_q, rd_state_q;
  beat_t      wr_beat_q, rd_beat_q;
  id_t        wr_id_q;
  logic       err_wr_overlap_q, err_rd_overlap_q;

  // A tap hit always starts a fresh burst; hitting mid-burst is flagged but still wins.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_state_q       <= IDLE;
      wr_beat_q        <= '0;
      wr_id_q          <= '0;
      err_wr_overlap_q <= 1'b0;
    end else begin
      err_wr_overlap_q <= wr_tap.valid && (wr_state_q == BURST) && (wr_beat_q != LAST_BEAT);
      if (wr_tap.valid) begin
        wr_state_q <= BURST;
        wr_beat_q  <= '0;
        wr_id_q    <= wr_tap.id;
      end else if (wr_state_q == BURST) begin
        if (wr_beat_q == LAST_BEAT) begin
          wr_state_q <= IDLE;
          wr_beat_q  <= '0;
        end else begin
          wr_beat_q <= wr_beat_q + beat_t'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_state_q       <= IDLE;
      rd_beat_q        <= '0;
      err_rd_overlap_q <= 1'b0;
    end else begin
      err_rd_overlap_q <= rd_tap.valid && (rd_state_q == BURST) && (rd_beat_q != LAST_BEAT);
      if (rd_tap.valid) begin
        rd_state_q <= BURST;
        rd_beat_q  <= '0;
      end else if (rd_state_q == BURST) begin
        if (rd_beat_q == LAST_BEAT) begin
          rd_state_q <= IDLE;
          rd_beat_q  <= '0;
        end else begin
          rd_beat_q <= rd_beat_q + beat_t'(1);
        end
      end
    end
  end

  id_t                   fifo_q [RD_FIFO_DEPTH];
  logic [FIFO_AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [FIFO_AW:0]      count_q, count_d;
  beat_t                 rx_beat_q, rx_beat_d;
  logic                  rsp_valid_q, rsp_valid_d, rsp_last_q, rsp_last_d;
  id_t                   rsp_id_q, rsp_id_d;
  logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic                  err_ovf_q, err_ovf_d, err_unexp_q, err_unexp_d;
  logic                  fifo_empty, fifo_full, beat_ok, push, pop;

  // A full FIFO still accepts a push when the final beat frees a slot in the same cycle.
  always_comb begin
    fifo_empty  = (count_q == '0);
    fifo_full   = (count_q == CNT_FULL);
    beat_ok     = bus.dfi_rddata_valid && !fifo_empty;
    pop         = beat_ok && (rx_beat_q == LAST_BEAT);
    push        = bus.rd_cmd_valid && (!fifo_full || pop);
    wr_ptr_d    = push ? wr_ptr_q + FIFO_AW'(1) : wr_ptr_q;
    rd_ptr_d    = pop ? rd_ptr_q + FIFO_AW'(1) : rd_ptr_q;
    count_d     = count_q;
    if (push && !pop) count_d = count_q + CNT_ONE;
    else if (pop && !push) count_d = count_q - CNT_ONE;
    rx_beat_d   = beat_ok ? rx_beat_q + beat_t'(1) : rx_beat_q;
    rsp_valid_d = beat_ok;
    rsp_last_d  = pop;
    rsp_id_d    = beat_ok ? fifo_q[rd_ptr_q] : rsp_id_q;
    rsp_data_d  = beat_ok ? bus.dfi_rddata : rsp_data_q;
    err_ovf_d   = bus.rd_cmd_valid && fifo_full && !pop;
    err_unexp_d = bus.dfi_rddata_valid && fifo_empty;
  end

  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q] <= bus.rd_cmd_id;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      rx_beat_q   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_last_q  <= 1'b0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
      err_ovf_q   <= 1'b0;
      err_unexp_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      rx_beat_q   <= rx_beat_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_last_q  <= rsp_last_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
      err_ovf_q   <= err_ovf_d;
      err_unexp_q <= err_unexp_d;
    end
  end

  assign bus.wbuf_req          = (wr_state_q == BURST);
  assign bus.wbuf_id           = wr_id_q;
  assign bus.wbuf_beat         = wr_beat_q;
  assign bus.dfi_wrdata_en     = (wr_state_q == BURST);
  assign bus.dfi_wrdata        = bus.wbuf_data;
  assign bus.dfi_wrdata_mask   = bus.wbuf_mask;
  assign bus.dfi_rddata_en     = (rd_state_q == BURST);
  assign bus.rd_rsp_valid      = rsp_valid_q;
  assign bus.rd_rsp_id         = rsp_id_q;
  assign bus.rd_rsp_last       = rsp_last_q;
  assign bus.rd_rsp_data       = rsp_data_q;
  assign bus.err_wr_overlap    = err_wr_overlap_q;
  assign bus.err_rd_overlap    = err_rd_overlap_q;
  assign bus.err_rd_overflow   = err_ovf_q;
  assign bus.err_rd_unexpected = err_unexp_q;

endmodule

// File: tb/tb_dfi_data_sched.sv
// Bench for dfi_data_sched: per-cycle stimulus tables replayed into the DUT and
// compared against a burst/queue reference model built from the command list.
module tb_dfi_data_sched;
  import dfi_data_sched_pkg::*;

  localparam int NC = 256;
  localparam int B  = BURST_CYCLES;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dfi_data_sched_if bus ();
  dfi_data_sched dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  function automatic logic [DATA_WIDTH-1:0] wdata(id_t id, int beat);
    return {16{id, beat_t'(beat), 2'b10}};
  endfunction
  function automatic logic [MASK_WIDTH-1:0] wmask(id_t id, int beat);
    return {2{id, beat_t'(beat), 2'b01}};
  endfunction

  // Write-buffer stand-in: combinational data keyed by the fetch tag and beat.
  assign bus.wbuf_data = bus.wbuf_req ? wdata(bus.wbuf_id, int'(bus.wbuf_beat)) : '0;
  assign bus.wbuf_mask = bus.wbuf_req ? wmask(bus.wbuf_id, int'(bus.wbuf_beat)) : '0;

  int checks = 0;
  int errors = 0;

  bit s_rst [NC]; bit s_wr [NC]; id_t s_wr_id [NC]; bit s_rd [NC]; id_t s_rd_id [NC];
  bit s_phy [NC]; logic [DATA_WIDTH-1:0] s_phy_data [NC];

  logic o_wr_en [NC]; logic o_req [NC]; id_t o_wr_id [NC]; beat_t o_wr_beat [NC];
  logic [DATA_WIDTH-1:0] o_wdata [NC]; logic [MASK_WIDTH-1:0] o_wmask [NC];
  logic o_err_wr [NC]; logic o_rd_en [NC]; logic o_err_rd [NC];
  logic o_rsp_v [NC]; id_t o_rsp_id [NC]; logic o_rsp_last [NC];
  logic [DATA_WIDTH-1:0] o_rsp_data [NC]; logic o_ovf [NC]; logic o_unexp [NC];

  bit e_wr_en [NC]; id_t e_wr_id [NC]; int e_wr_beat [NC]; bit e_err_wr [NC];
  bit e_rd_en [NC]; int e_rd_beat [NC]; bit e_err_rd [NC];
  bit e_rsp_v [NC]; id_t e_rsp_id [NC]; bit e_rsp_last [NC];
  logic [DATA_WIDTH-1:0] e_rsp_data [NC]; bit e_ovf [NC]; bit e_unexp [NC];

  task automatic clear_stim();
    for (int k = 0; k < NC; k++) begin
      s_rst[k] = 1'b1; s_wr[k] = 1'b0; s_wr_id[k] = '0; s_rd[k] = 1'b0; s_rd_id[k] = '0;
      s_phy[k] = 1'b0; s_phy_data[k] = '0;
    end
  endtask

  // A burst beat at cycle c from a command at t survives only if no reset edge lies in [t, c-1].
  function automatic bit killed(int t, int c);
    for (int r = t; r < c; r++) if (r < NC && !s_rst[r]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic build_model(input int n, input int wl, input int rl);
    id_t q [$];
    int bt;
    bit pop;
    for (int k = 0; k < NC; k++) begin
      e_wr_en[k] = 0; e_wr_id[k] = '0; e_wr_beat[k] = 0; e_err_wr[k] = 0;
      e_rd_en[k] = 0; e_rd_beat[k] = 0; e_err_rd[k] = 0;
      e_rsp_v[k] = 0; e_rsp_id[k] = '0; e_rsp_last[k] = 0; e_rsp_data[k] = '0;
      e_ovf[k] = 0; e_unexp[k] = 0;
    end
    // later commands overwrite the tail of earlier bursts: new burst wins
    for (int t = 0; t < n; t++) begin
      for (int b = 0; b < B; b++) begin
        int c;
        c = t + wl + b;
        if (s_wr[t] && c < NC && !killed(t, c)) begin
          if (b == 0 && e_wr_en[c-1] && e_wr_beat[c-1] != B - 1) e_err_wr[c] = 1;
          e_wr_en[c] = 1; e_wr_id[c] = s_wr_id[t]; e_wr_beat[c] = b;
        end
        c = t + rl + b;
        if (s_rd[t] && c < NC && !killed(t, c)) begin
          if (b == 0 && e_rd_en[c-1] && e_rd_beat[c-1] != B - 1) e_err_rd[c] = 1;
          e_rd_en[c] = 1; e_rd_beat[c] = b;
        end
      end
    end
    bt = 0;
    for (int k = 0; k < n && k + 1 < NC; k++) begin
      if (!s_rst[k]) begin
        q.delete(); bt = 0;
      end else begin
        pop = 0;
        if (s_phy[k]) begin
          if (q.size() == 0) e_unexp[k+1] = 1;
          else begin
            e_rsp_v[k+1] = 1; e_rsp_id[k+1] = q[0]; e_rsp_data[k+1] = s_phy_data[k];
            e_rsp_last[k+1] = (bt == B - 1);
            pop = (bt == B - 1);
            bt = (bt + 1) % B;
          end
        end
        if (s_rd[k] && q.size() == RD_FIFO_DEPTH && !pop) e_ovf[k+1] = 1;
        if (pop) void'(q.pop_front());
        if (s_rd[k] && !e_ovf[k+1]) q.push_back(s_rd_id[k]);
      end
    end
  endtask

  task automatic run(input int n, input int wl, input int rl);
    bus.cfg_wr_lat = LAT_W'(wl); bus.cfg_rd_lat = LAT_W'(rl);
    rst_n = 1'b0; bus.wr_cmd_valid = 0; bus.wr_cmd_id = '0; bus.rd_cmd_valid = 0;
    bus.rd_cmd_id = '0; bus.dfi_rddata_valid = 0; bus.dfi_rddata = '0;
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < n; k++) begin
      rst_n = s_rst[k];
      bus.wr_cmd_valid = s_wr[k]; bus.wr_cmd_id = s_wr_id[k];
      bus.rd_cmd_valid = s_rd[k]; bus.rd_cmd_id = s_rd_id[k];
      bus.dfi_rddata_valid = s_phy[k]; bus.dfi_rddata = s_phy_data[k];
      #1;
      o_wr_en[k] = bus.dfi_wrdata_en; o_req[k] = bus.wbuf_req; o_wr_id[k] = bus.wbuf_id;
      o_wr_beat[k] = bus.wbuf_beat; o_wdata[k] = bus.dfi_wrdata; o_wmask[k] = bus.dfi_wrdata_mask;
      o_err_wr[k] = bus.err_wr_overlap; o_rd_en[k] = bus.dfi_rddata_en; o_err_rd[k] = bus.err_rd_overlap;
      o_rsp_v[k] = bus.rd_rsp_valid; o_rsp_id[k] = bus.rd_rsp_id; o_rsp_last[k] = bus.rd_rsp_last;
      o_rsp_data[k] = bus.rd_rsp_data; o_ovf[k] = bus.err_rd_overflow; o_unexp[k] = bus.err_rd_unexpected;
      @(posedge clk);
      #1;
    end
    build_model(n, wl, rl);
  endtask

  task automatic test_reset();
    clear_stim();
    run(3, 1, 1);
    checks++; if (o_wr_en[0] !== 1'b0) begin errors++; $display("FAIL reset_wr_en got %0b exp 0", o_wr_en[0]); end
    checks++; if (o_req[0] !== 1'b0) begin errors++; $display("FAIL reset_wbuf_req got %0b exp 0", o_req[0]); end
    checks++; if (o_wr_id[0] !== '0 || o_wr_beat[0] !== '0) begin errors++; $display("FAIL reset_wbuf_id_beat got %0h/%0h exp 0/0", o_wr_id[0], o_wr_beat[0]); end
    checks++; if (o_wdata[0] !== '0) begin errors++; $display("FAIL reset_wrdata got %0h exp 0", o_wdata[0]); end
    checks++; if (o_rd_en[0] !== 1'b0) begin errors++; $display("FAIL reset_rd_en got %0b exp 0", o_rd_en[0]); end
    checks++; if ({o_rsp_v[0], o_rsp_last[0], o_rsp_id[0]} !== '0 || o_rsp_data[0] !== '0) begin errors++; $display("FAIL reset_rsp got v%0b l%0b id%0h d%0h exp all 0", o_rsp_v[0], o_rsp_last[0], o_rsp_id[0], o_rsp_data[0]); end
    checks++; if ({o_err_wr[0], o_err_rd[0], o_ovf[0], o_unexp[0]} !== 4'b0) begin errors++; $display("FAIL reset_errs got %b exp 0000", {o_err_wr[0], o_err_rd[0], o_ovf[0], o_unexp[0]}); end
  endtask

  // single burst, seamless back-to-back, and mid-burst overlap
  task automatic test_write_timing();
    int sc [3][2];
    int en_total [3];
    int cnt;
    sc = '{'{10, -1}, '{10, 14}, '{10, 12}};
    en_total = '{4, 8, 6};
    for (int s = 0; s < 3; s++) begin
      clear_stim();
      s_wr[sc[s][0]] = 1; s_wr_id[sc[s][0]] = id_t'($urandom_range(1, 7));
      if (sc[s][1] >= 0) begin s_wr[sc[s][1]] = 1; s_wr_id[sc[s][1]] = id_t'($urandom_range(8, 15)); end
      run(26, 3, 1);
      cnt = 0;
      for (int k = 0; k < 26; k++) begin
        cnt += int'(o_wr_en[k]);
        checks++; if (o_wr_en[k] !== e_wr_en[k]) begin errors++; $display("FAIL wr_en sc%0d cyc %0d got %0b exp %0b", s, k, o_wr_en[k], e_wr_en[k]); end
        checks++; if (o_req[k] !== e_wr_en[k]) begin errors++; $display("FAIL wbuf_req sc%0d cyc %0d got %0b exp %0b", s, k, o_req[k], e_wr_en[k]); end
        checks++; if (o_err_wr[k] !== e_err_wr[k]) begin errors++; $display("FAIL err_wr_overlap sc%0d cyc %0d got %0b exp %0b", s, k, o_err_wr[k], e_err_wr[k]); end
        if (e_wr_en[k]) begin
          checks++; if (o_wr_id[k] !== e_wr_id[k] || o_wr_beat[k] !== beat_t'(e_wr_beat[k])) begin errors++; $display("FAIL wbuf_id_beat sc%0d cyc %0d got %0h/%0d exp %0h/%0d", s, k, o_wr_id[k], o_wr_beat[k], e_wr_id[k], e_wr_beat[k]); end
          checks++; if (o_wdata[k] !== wdata(e_wr_id[k], e_wr_beat[k]) || o_wmask[k] !== wmask(e_wr_id[k], e_wr_beat[k])) begin errors++; $display("FAIL wrdata sc%0d cyc %0d got %0h/%0h exp %0h/%0h", s, k, o_wdata[k], o_wmask[k], wdata(e_wr_id[k], e_wr_beat[k]), wmask(e_wr_id[k], e_wr_beat[k])); end
        end
      end
      checks++; if (cnt != en_total[s]) begin errors++; $display("FAIL wr_en_cycles sc%0d got %0d exp %0d", s, cnt, en_total[s]); end
    end
  endtask

  task automatic test_read();
    clear_stim();
    s_rd[20] = 1; s_rd_id[20] = id_t'(7);
    for (int k = 27; k <= 30; k++) begin s_phy[k] = 1; s_phy_data[k] = {$urandom, $urandom, $urandom, $urandom}; end
    run(40, 1, 5);
    for (int k = 0; k < 40; k++) begin
      checks++; if (o_rd_en[k] !== e_rd_en[k]) begin errors++; $display("FAIL rd_en cyc %0d got %0b exp %0b", k, o_rd_en[k], e_rd_en[k]); end
      checks++; if (o_rsp_v[k] !== e_rsp_v[k] || o_rsp_last[k] !== e_rsp_last[k]) begin errors++; $display("FAIL rsp_valid_last cyc %0d got %0b%0b exp %0b%0b", k, o_rsp_v[k], o_rsp_last[k], e_rsp_v[k], e_rsp_last[k]); end
      if (e_rsp_v[k]) begin
        checks++; if (o_rsp_id[k] !== e_rsp_id[k] || o_rsp_data[k] !== e_rsp_data[k]) begin errors++; $display("FAIL rsp_id_data cyc %0d got %0h/%0h exp %0h/%0h", k, o_rsp_id[k], o_rsp_data[k], e_rsp_id[k], e_rsp_data[k]); end
      end
    end
    checks++; if (o_rsp_last[31] !== 1'b1 || o_rsp_id[31] !== id_t'(7)) begin errors++; $display("FAIL rsp_last_at_31 got l%0b id%0h exp l1 id7", o_rsp_last[31], o_rsp_id[31]); end
  endtask

  // stray beat on empty FIFO, 9 reads into depth 8, then push+pop while full
  task automatic test_fifo_errors();
    clear_stim();
    s_phy[1] = 1; s_phy_data[1] = {4{$urandom}};
    for (int k = 3; k <= 11; k++) begin s_rd[k] = 1; s_rd_id[k] = id_t'($urandom); end
    for (int k = 20; k <= 23; k++) begin s_phy[k] = 1; s_phy_data[k] = {4{$urandom}}; end
    s_rd[23] = 1; s_rd_id[23] = id_t'($urandom);
    for (int k = 30; k <= 33; k++) begin s_phy[k] = 1; s_phy_data[k] = {4{$urandom}}; end
    run(40, 1, 2);
    for (int k = 0; k < 40; k++) begin
      checks++; if (o_ovf[k] !== e_ovf[k]) begin errors++; $display("FAIL err_rd_overflow cyc %0d got %0b exp %0b", k, o_ovf[k], e_ovf[k]); end
      checks++; if (o_unexp[k] !== e_unexp[k]) begin errors++; $display("FAIL err_rd_unexpected cyc %0d got %0b exp %0b", k, o_unexp[k], e_unexp[k]); end
      checks++; if (o_err_rd[k] !== e_err_rd[k] || o_rd_en[k] !== e_rd_en[k]) begin errors++; $display("FAIL rd_en_overlap cyc %0d got %0b%0b exp %0b%0b", k, o_rd_en[k], o_err_rd[k], e_rd_en[k], e_err_rd[k]); end
      checks++; if (o_rsp_v[k] !== e_rsp_v[k] || o_rsp_last[k] !== e_rsp_last[k]) begin errors++; $display("FAIL rsp_valid_last cyc %0d got %0b%0b exp %0b%0b", k, o_rsp_v[k], o_rsp_last[k], e_rsp_v[k], e_rsp_last[k]); end
      if (e_rsp_v[k]) begin
        checks++; if (o_rsp_id[k] !== e_rsp_id[k]) begin errors++; $display("FAIL rsp_id cyc %0d got %0h exp %0h", k, o_rsp_id[k], e_rsp_id[k]); end
      end
    end
    checks++; if (o_unexp[2] !== 1'b1 || o_rsp_v[2] !== 1'b0) begin errors++; $display("FAIL stray_beat got unexp%0b v%0b exp unexp1 v0", o_unexp[2], o_rsp_v[2]); end
  endtask

  // reset at beat 2; commands queued before or at the reset edge must vanish
  task automatic test_reset_mid_burst();
    clear_stim();
    s_wr[10] = 1; s_wr_id[10] = id_t'(3);
    s_wr[14] = 1; s_wr_id[14] = id_t'(9);
    s_wr[15] = 1; s_wr_id[15] = id_t'(12);
    s_rd[12] = 1; s_rd_id[12] = id_t'(6);
    s_rst[15] = 0;
    s_phy[20] = 1; s_phy_data[20] = {4{$urandom}};
    run(30, 3, 8);
    for (int k = 0; k < 30; k++) begin
      checks++; if (o_wr_en[k] !== e_wr_en[k] || o_req[k] !== e_wr_en[k]) begin errors++; $display("FAIL rst_wr_en cyc %0d got %0b%0b exp %0b", k, o_wr_en[k], o_req[k], e_wr_en[k]); end
      checks++; if (o_rd_en[k] !== e_rd_en[k]) begin errors++; $display("FAIL rst_rd_en cyc %0d got %0b exp %0b", k, o_rd_en[k], e_rd_en[k]); end
      checks++; if (o_unexp[k] !== e_unexp[k] || o_rsp_v[k] !== e_rsp_v[k]) begin errors++; $display("FAIL rst_return cyc %0d got u%0b v%0b exp u%0b v%0b", k, o_unexp[k], o_rsp_v[k], e_unexp[k], e_rsp_v[k]); end
    end
    checks++; if (o_wr_en[15] !== 1'b1 || o_wr_en[16] !== 1'b0) begin errors++; $display("FAIL abort_edge got %0b%0b exp 10", o_wr_en[15], o_wr_en[16]); end
  endtask

  task automatic test_random();
    int wl, rl;
    for (int it = 0; it < 4; it++) begin
      clear_stim();
      wl = $urandom_range(1, MAX_LAT); rl = $urandom_range(1, MAX_LAT);
      for (int k = 0; k < 200; k++) begin
        s_wr[k] = ($urandom_range(0, 3) == 0); s_wr_id[k] = id_t'($urandom);
        s_rd[k] = ($urandom_range(0, 4) == 0); s_rd_id[k] = id_t'($urandom);
        s_phy[k] = ($urandom_range(0, 2) == 0); s_phy_data[k] = {$urandom, $urandom, $urandom, $urandom};
      end
      run(200, wl, rl);
      for (int k = 0; k < 200; k++) begin
        checks++; if (o_wr_en[k] !== e_wr_en[k] || o_err_wr[k] !== e_err_wr[k]) begin errors++; $display("FAIL rnd%0d wr cyc %0d got en%0b e%0b exp en%0b e%0b", it, k, o_wr_en[k], o_err_wr[k], e_wr_en[k], e_err_wr[k]); end
        if (e_wr_en[k]) begin
          checks++; if (o_wdata[k] !== wdata(e_wr_id[k], e_wr_beat[k]) || o_wr_beat[k] !== beat_t'(e_wr_beat[k])) begin errors++; $display("FAIL rnd%0d wrdata cyc %0d got %0h b%0d exp %0h b%0d", it, k, o_wdata[k], o_wr_beat[k], wdata(e_wr_id[k], e_wr_beat[k]), e_wr_beat[k]); end
        end
        checks++; if (o_rd_en[k] !== e_rd_en[k] || o_err_rd[k] !== e_err_rd[k]) begin errors++; $display("FAIL rnd%0d rd cyc %0d got en%0b e%0b exp en%0b e%0b", it, k, o_rd_en[k], o_err_rd[k], e_rd_en[k], e_err_rd[k]); end
        checks++; if (o_rsp_v[k] !== e_rsp_v[k] || o_rsp_last[k] !== e_rsp_last[k] || o_ovf[k] !== e_ovf[k] || o_unexp[k] !== e_unexp[k]) begin errors++; $display("FAIL rnd%0d ret cyc %0d got v%0b l%0b o%0b u%0b exp v%0b l%0b o%0b u%0b", it, k, o_rsp_v[k], o_rsp_last[k], o_ovf[k], o_unexp[k], e_rsp_v[k], e_rsp_last[k], e_ovf[k], e_unexp[k]); end
        if (e_rsp_v[k]) begin
          checks++; if (o_rsp_id[k] !== e_rsp_id[k] || o_rsp_data[k] !== e_rsp_data[k]) begin errors++; $display("FAIL rnd%0d rsp cyc %0d got %0h/%0h exp %0h/%0h", it, k, o_rsp_id[k], o_rsp_data[k], e_rsp_id[k], e_rsp_data[k]); end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_write_timing();
    test_read();
    test_fifo_errors();
    test_reset_mid_burst();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
